// File: rtl/pu_run_sequencer_if.sv
// Bus between the run sequencer, the host request side and reg_pu.
// Request handshake: a start address transfers on a rising clock edge
// where req_valid_i and req_ready_o are both high; the host holds
// req_addr_i stable while req_valid_i is high, and req_ready_o never
// depends on req_valid_i. Results have no backpressure: res_valid_o is a
// one-cycle strobe.
// state_dbg mirrors the sequencer FSM state (0 IDLE, 1 START, 2 RUN, 3 REPORT).
interface pu_run_sequencer_if #(
    parameter int ADDR_W = 8,
    parameter int CNT_W  = 15
);
    logic              req_valid_i;
    logic [ADDR_W-1:0] req_addr_i;
    logic              req_ready_o;
    logic              pu_start_o;
    logic [ADDR_W-1:0] pu_start_addr_o;
    logic              pu_done_i;
    logic              res_valid_o;
    logic [ADDR_W-1:0] res_addr_o;
    logic [CNT_W-1:0]  res_cycles_o;
    logic              res_timeout_o;
    logic              busy_o;
    logic [1:0]        state_dbg;

    // Host / processor-model side.
    modport master (
        output req_valid_i, req_addr_i, pu_done_i,
        input  req_ready_o, pu_start_o, pu_start_addr_o, res_valid_o,
               res_addr_o, res_cycles_o, res_timeout_o, busy_o, state_dbg
    );

    // Sequencer side.
    modport slave (
        input  req_valid_i, req_addr_i, pu_done_i,
        output req_ready_o, pu_start_o, pu_start_addr_o, res_valid_o,
               res_addr_o, res_cycles_o, res_timeout_o, busy_o, state_dbg
    );
endinterface

// File: rtl/pu_run_sequencer.sv
// Run sequencer for reg_pu: queues host start addresses in a small FIFO,
// launches each program with a one-cycle start pulse, waits for a rising
// edge of done and reports the address plus the RUN cycle count.
// Optional watchdog: define RUN_SEQ_WATCHDOG_EN to end a run that reaches
// TIMEOUT RUN cycles without completing (result flagged as timed out).
module pu_run_sequencer #(
    parameter int               ADDR_W  = 8,
    parameter int               DEPTH   = 4,
    parameter int               CNT_W   = 15,
    parameter logic [CNT_W-1:0] TIMEOUT = 15'd20000
) (
    input logic               clock_i,
    input logic               reset_i,
    pu_run_sequencer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        START  = 2'd1,
        RUN    = 2'd2,
        REPORT = 2'd3
    } state_t;

    state_t state, state_next;

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr, rd_ptr;
    logic [CW-1:0]     count;
    logic              push, pop;

    logic              done_q, done_rise;
    logic [CNT_W-1:0]  counter, cnt_inc;
    logic              finish, timed_out, wd_hit;

    logic [ADDR_W-1:0] start_addr;
    logic [ADDR_W-1:0] res_addr;
    logic [CNT_W-1:0]  res_cycles;

    assign push      = bus.req_valid_i & bus.req_ready_o;
    assign pop       = (state == IDLE) && (count != '0);
    assign done_rise = bus.pu_done_i & ~done_q;
    assign cnt_inc   = (counter == '1) ? counter : counter + 1'b1;

`ifdef RUN_SEQ_WATCHDOG_EN
    logic res_timeout;
    // cnt_inc is the number of RUN cycles including the current one.
    assign wd_hit            = (cnt_inc >= TIMEOUT);
    assign bus.res_timeout_o = res_timeout;
`else
    assign wd_hit            = 1'b0;
    assign bus.res_timeout_o = 1'b0;
`endif

    // FSM state register.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) state <= IDLE;
        else         state <= state_next;
    end

    // Next-state decode; a done edge wins over the watchdog in the same cycle.
    always_comb begin
        state_next = state;
        finish     = 1'b0;
        timed_out  = 1'b0;
        case (state)
            IDLE:   if (count != '0) state_next = START;
            START:  state_next = RUN;
            RUN: begin
                if (done_rise) begin
                    state_next = REPORT;
                    finish     = 1'b1;
                end else if (wd_hit) begin
                    state_next = REPORT;
                    finish     = 1'b1;
                    timed_out  = 1'b1;
                end
            end
            REPORT: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^AW).
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // FIFO storage; contents are don't-care until written.
    always_ff @(posedge clock_i) begin
        if (push) mem[wr_ptr] <= bus.req_addr_i;
    end

    // Done history for rising-edge detection, sampled every cycle.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) done_q <= 1'b0;
        else         done_q <= bus.pu_done_i;
    end

    // RUN cycle counter: cleared in START, saturating increment in RUN.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)               counter <= '0;
        else if (state == START)   counter <= '0;
        else if (state == RUN)     counter <= cnt_inc;
    end

    // Launch address register, loaded on the IDLE to START pop.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)  start_addr <= '0;
        else if (pop) start_addr <= mem[rd_ptr];
    end

    // Result record, captured when the run ends and held until the next one.
    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            res_addr    <= '0;
            res_cycles  <= '0;
`ifdef RUN_SEQ_WATCHDOG_EN
            res_timeout <= 1'b0;
`endif
        end else if (finish) begin
            res_addr    <= start_addr;
            res_cycles  <= timed_out ? TIMEOUT : cnt_inc;
`ifdef RUN_SEQ_WATCHDOG_EN
            res_timeout <= timed_out;
`endif
        end
    end

    assign bus.req_ready_o     = (count != CW'(DEPTH));
    assign bus.pu_start_o      = (state == START);
    assign bus.pu_start_addr_o = start_addr;
    assign bus.res_valid_o     = (state == REPORT);
    assign bus.res_addr_o      = res_addr;
    assign bus.res_cycles_o    = res_cycles;
    assign bus.busy_o          = (state != IDLE) || (count != '0);
    assign bus.state_dbg       = state;
endmodule

// File: tb/tb_pu_run_sequencer.sv
// Directed bench for pu_run_sequencer: a host driver pushes start
// addresses, a processor model raises done at a planned cycle, and the
// scoreboard queue holds {timeout, cycles, addr} per accepted request.
module tb_pu_run_sequencer;
    localparam int ADDR_W = 8;
    localparam int CNT_W  = 15;
    localparam int EW     = ADDR_W + CNT_W + 1;
    localparam logic [CNT_W-1:0] WD_LIMIT = 15'd50;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;
    int   checks   = 0;
    int   failures = 0;
    bit   pushes_done = 1'b0;

    logic [EW-1:0] exp_q[$];

    pu_run_sequencer_if #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) bus ();

    pu_run_sequencer #(
        .ADDR_W(ADDR_W), .DEPTH(4), .CNT_W(CNT_W), .TIMEOUT(WD_LIMIT)
    ) dut (
        .clock_i(clock_i),
        .reset_i(reset_i),
        .bus    (bus)
    );

    // Clock and reset.
    always #5 clock_i = ~clock_i;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, " pu_start"},      32'(bus.pu_start_o), 0);
        check({tag, " pu_start_addr"}, 32'(bus.pu_start_addr_o), 0);
        check({tag, " res_valid"},     32'(bus.res_valid_o), 0);
        check({tag, " res_addr"},      32'(bus.res_addr_o), 0);
        check({tag, " res_cycles"},    32'(bus.res_cycles_o), 0);
        check({tag, " res_timeout"},   32'(bus.res_timeout_o), 0);
        check({tag, " busy"},          32'(bus.busy_o), 0);
        check({tag, " req_ready"},     32'(bus.req_ready_o), 1);
    endtask

    // Host driver: offer one address, record its planned result, hold
    // valid until the edge that accepts it.
    task automatic push_req(input logic [ADDR_W-1:0] a, input int cyc, input logic to);
        int n = 0;
        bus.req_valid_i = 1'b1;
        bus.req_addr_i  = a;
        exp_q.push_back({to, CNT_W'(cyc), a});
        while (bus.req_ready_o !== 1'b1 && n < 400) begin
            @(negedge clock_i);
            n++;
        end
        check("push ready", 32'(bus.req_ready_o), 1);
        @(negedge clock_i);
        bus.req_valid_i = 1'b0;
    endtask

    // Wait (bounded) for a start pulse and compare its address with the queue head.
    task automatic wait_start(input string tag);
        int n = 0;
        while (bus.pu_start_o !== 1'b1 && n < 300) begin
            @(negedge clock_i);
            n++;
        end
        check({tag, " start seen"}, 32'(bus.pu_start_o), 1);
        if (exp_q.size() != 0)
            check({tag, " start addr"}, 32'(bus.pu_start_addr_o), 32'(exp_q[0][ADDR_W-1:0]));
        else
            check({tag, " queue empty at start"}, 32'(exp_q.size()), 1);
    endtask

    // Processor model: done drops at drop_at and rises at rise_at cycles
    // after the start cycle; then the result strobe is checked against the queue.
    task automatic finish_run(input string tag, input int rise_at, input int drop_at, input bit keep);
        logic [EW-1:0] e;
        for (int i = 1; i <= rise_at; i++) begin
            @(negedge clock_i);
            if (i == 1) check({tag, " start one cycle"}, 32'(bus.pu_start_o), 0);
            check({tag, " no early result"}, 32'(bus.res_valid_o), 0);
            if (i == drop_at) bus.pu_done_i = 1'b0;
            if (i == rise_at) bus.pu_done_i = 1'b1;
        end
        @(negedge clock_i);
        check({tag, " res_valid"}, 32'(bus.res_valid_o), 1);
        if (exp_q.size() == 0) begin
            check({tag, " queue empty at result"}, 32'(exp_q.size()), 1);
        end else begin
            e = exp_q.pop_front();
            check({tag, " res_addr"},    32'(bus.res_addr_o), 32'(e[ADDR_W-1:0]));
            check({tag, " res_cycles"},  32'(bus.res_cycles_o), 32'(e[ADDR_W +: CNT_W]));
            check({tag, " res_timeout"}, 32'(bus.res_timeout_o), 32'(e[EW-1]));
        end
        if (!keep) bus.pu_done_i = 1'b0;
        @(negedge clock_i);
        check({tag, " res_valid one cycle"}, 32'(bus.res_valid_o), 0);
    endtask

    initial begin
        bus.req_valid_i = 1'b0;
        bus.req_addr_i  = '0;
        bus.pu_done_i   = 1'b0;

        // Reset state.
        repeat (3) @(negedge clock_i);
        check_reset_outputs("reset");
        reset_i = 1'b0;
        @(negedge clock_i);
        check_reset_outputs("after release");

        // Single run of address 0, 37 cycles; meanwhile fill the FIFO.
        push_req(8'd0, 37, 1'b0);
        fork
            begin
                push_req(8'd93, 5, 1'b0);
                push_req(8'd138, 1, 1'b0);
                push_req(8'd7, 9, 1'b0);
                push_req(8'd200, 4, 1'b0);
                check("fifo full ready low", 32'(bus.req_ready_o), 0);
                check("fifo full busy", 32'(bus.busy_o), 1);
                push_req(8'd55, 20, 1'b0);
                pushes_done = 1'b1;
            end
        join_none
        wait_start("run0");
        finish_run("run0", 37, 0, 1'b0);

        // Queued runs in order; 138 completes in its first RUN cycle, 200
        // leaves done high and 55 sees it drop then rise.
        wait_start("run93");
        finish_run("run93", 5, 0, 1'b0);
        wait_start("run138");
        finish_run("run138", 1, 0, 1'b0);
        wait_start("run7");
        finish_run("run7", 9, 0, 1'b0);
        wait_start("run200");
        finish_run("run200", 4, 0, 1'b1);
        wait_start("run55");
        finish_run("run55", 20, 3, 1'b0);
        check("all pushes accepted", 32'(pushes_done), 1);
        check("scoreboard drained", 32'(exp_q.size()), 0);
        repeat (2) @(negedge clock_i);
        check("idle busy low", 32'(bus.busy_o), 0);

        // Reset mid-RUN with two entries queued behind the active run.
        push_req(8'd10, 30, 1'b0);
        wait_start("run10");
        push_req(8'd11, 3, 1'b0);
        push_req(8'd12, 3, 1'b0);
        @(negedge clock_i);
        check("mid-run state", 32'(bus.state_dbg), 2);
        check("mid-run busy", 32'(bus.busy_o), 1);
        reset_i = 1'b1;
        #1;
        check_reset_outputs("mid-run reset");
        exp_q.delete();
        repeat (2) @(negedge clock_i);
        reset_i = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clock_i);
            check("discarded no start", 32'(bus.pu_start_o), 0);
            check("discarded no result", 32'(bus.res_valid_o), 0);
            check("discarded idle", 32'(bus.busy_o), 0);
        end
        push_req(8'd77, 6, 1'b0);
        wait_start("run77");
        finish_run("run77", 6, 0, 1'b0);

`ifdef RUN_SEQ_WATCHDOG_EN
        // Watchdog: 60 never completes, 61 must launch two cycles after the report.
        begin
            int n = 0;
            logic [EW-1:0] e;
            push_req(8'd60, 50, 1'b1);
            push_req(8'd61, 3, 1'b0);
            wait_start("run60");
            while (bus.res_valid_o !== 1'b1 && n < 200) begin
                @(negedge clock_i);
                n++;
            end
            check("wd report cycle", 32'(n), 51);
            check("wd res_valid", 32'(bus.res_valid_o), 1);
            e = exp_q.pop_front();
            check("wd res_addr", 32'(bus.res_addr_o), 32'(e[ADDR_W-1:0]));
            check("wd res_cycles", 32'(bus.res_cycles_o), 32'(e[ADDR_W +: CNT_W]));
            check("wd res_timeout", 32'(bus.res_timeout_o), 32'(e[EW-1]));
            @(negedge clock_i);
            check("wd gap start low", 32'(bus.pu_start_o), 0);
            @(negedge clock_i);
            check("wd next start", 32'(bus.pu_start_o), 1);
            check("wd next addr", 32'(bus.pu_start_addr_o), 32'(exp_q[0][ADDR_W-1:0]));
            finish_run("run61", 3, 0, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pu_run_sequencer.md
# pu_run_sequencer

Run sequencer for the reg_pu pipelined processor. Accepts program start addresses from a host-side request port, queues them in a small FIFO, and launches each program on the processor in turn: a one-cycle start pulse with the address, then a wait for completion. Each run produces a result record with the program address and its dynamic cycle count. This replaces hand-driven start/done sequencing with a reusable controller between the host and reg_pu.

## Interface
- ADDR_W, 8, width of program start address
- DEPTH, 4, request FIFO entries (power of two, ≥2)
- CNT_W, 15, width of the dynamic cycle counter
- TIMEOUT, 15'd20000, watchdog limit in RUN cycles (used only with the watchdog macro)

- clock_i  in  1  processor clock; all state updates on rising edge
- reset_i  in  1  asynchronous, active-high reset
- req_valid_i  in  1  host offers a start address
- req_addr_i  in  ADDR_W  program start address
- req_ready_o  out  1  FIFO not full; a request is accepted on an edge where req_valid_i & req_ready_o
- pu_start_o  out  1  start pulse to reg_pu start_i
- pu_start_addr_o  out  ADDR_W  to reg_pu start_addr_i
- pu_done_i  in  1  reg_pu done
- res_valid_o  out  1  one-cycle result strobe; no backpressure
- res_addr_o  out  ADDR_W  address of the completed run
- res_cycles_o  out  CNT_W  RUN cycles consumed
- res_timeout_o  out  1  run ended by watchdog
- busy_o  out  1  state ≠ IDLE or FIFO non-empty

## Operation
- FSM states: IDLE, START, RUN, REPORT.
- IDLE: if FIFO non-empty, pop head into pu_start_addr_o register, go to START; otherwise stay.
- START: pu_start_o = 1 for exactly this cycle; counter cleared to 0; go to RUN.
- RUN: counter increments each cycle, saturating at all-ones. Completion is a rising edge of pu_done_i, detected as pu_done_i & ~done_q, where done_q is pu_done_i registered every cycle. A done level that is already high and never drops is not completion. On completion, capture res_cycles_o = counter+1 (saturating) and res_timeout_o = 0, then go to REPORT.
- REPORT: res_valid_o = 1, res_addr_o = launched address; go to IDLE.
- FIFO: push when req_valid_i & req_ready_o; pop only on the IDLE→START transition. Push and pop on the same edge are both performed. A push when full cannot occur because ready is low. Requests are launched in order.
- pu_start_addr_o and res_* hold their values until the next launch or report.
- Reset (any time, including mid-RUN): state IDLE, FIFO empty, counter 0, done_q 0. Outputs after reset: pu_start_o 0, pu_start_addr_o 0, res_valid_o 0, res_addr_o 0, res_cycles_o 0, res_timeout_o 0, busy_o 0, req_ready_o 1. An in-flight run is abandoned with no result.

## Timing
- All outputs are registered or decoded from state only; there are no combinational input-to-output paths except req_ready_o, which is derived from FIFO count.
- Request accepted at edge N into an empty FIFO while IDLE: pop at edge N+1, pu_start_o high during cycle N+1..N+2.
- Done rising edge sampled at edge M in RUN: res_valid_o high during cycle M..M+1.
- Back-to-back runs: REPORT → IDLE → START, so successive start pulses are separated by at least RUN+2 cycles.
- res_cycles_o equals the number of RUN cycles including the cycle in which the done edge was sampled. The minimum is 1.

## Configuration
- RUN_SEQ_WATCHDOG_EN defined: in RUN, if the counter reaches TIMEOUT with no done edge, go to REPORT with res_cycles_o = TIMEOUT and res_timeout_o = 1. A done edge in the same cycle takes priority and reports a normal completion.
- Not defined: no watchdog. RUN waits indefinitely, res_timeout_o is tied 0, and TIMEOUT is ignored.

## Test plan
- Reset, push addr 8'd0; model done rises 37 cycles after start → exactly one 1-cycle pu_start_o with addr 0, then res_valid_o with res_addr_o = 0, res_cycles_o = 37, res_timeout_o = 0.
- Push 93, 138, 7, 200, 55 back-to-back → req_ready_o low after 4 accepted while the first is still queued; runs launch in order 93, 138, 7, 200, 55 once the stalled request is accepted; five results in the same order.
- Done held high from the previous run, dropping 3 cycles after start and rising at 20 → only the rise counts; res_cycles_o = 20.
- Assert reset_i mid-RUN with two queued entries → all outputs return to reset values immediately, no res_valid_o, and the queued entries are discarded.
- With RUN_SEQ_WATCHDOG_EN and TIMEOUT = 50, done never rises → res_valid_o with res_cycles_o = 50, res_timeout_o = 1, and the next queued address launches 2 cycles later.
- Done rising edge in the first RUN cycle → res_cycles_o = 1.
